// File: rtl/fft_pkg.sv
// Shared constants and types for the 16-point radix-4 FFT core.
// The serial-to-parallel buffer imports this package.
package fft_pkg;
  localparam int SAMPLE_W     = 16;
  localparam int N            = 16;
  localparam int RADIX        = 4;
  localparam int GROUPS       = 4;
  localparam int S_P_FLAG_IDX = 12;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/s_p_bank.sv
// One 16-entry complex register file. It has a single write port and a
// 4-lane strided read port: lane j returns entry sel + 4j.
module s_p_bank
  import fft_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [3:0]             waddr_i,
  input  logic [WIDTH-1:0]       wre_i,
  input  logic [WIDTH-1:0]       wim_i,
  input  logic [1:0]             sel_i,
  output logic [RADIX*WIDTH-1:0] rd_re_o,
  output logic [RADIX*WIDTH-1:0] rd_im_o
);
  logic [WIDTH-1:0] re_q [N];
  logic [WIDTH-1:0] im_q [N];

  // Flops rather than RAM: every entry must clear on reset and all four
  // lanes are read at the same time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (we_i) begin
      re_q[waddr_i] <= wre_i;
      im_q[waddr_i] <= wim_i;
    end
  end

  generate
    for (genvar gi = 0; gi < RADIX; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign rd_re_o[gi*WIDTH +: WIDTH] = re_q[{LANE, sel_i}];
      assign rd_im_o[gi*WIDTH +: WIDTH] = im_q[{LANE, sel_i}];
    end
  endgenerate
endmodule

// File: rtl/s_p_buffer.sv
// Serial-to-parallel ping-pong input buffer for the 16-point radix-4 FFT.
// It raises a start flag as soon as sample 12 of a frame is stored.
module s_p_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic [WIDTH-1:0]   in_re,
  input  logic [WIDTH-1:0]   in_im,
  input  logic [1:0]         sel,
  output logic               s_p_flag_out,
  output logic [4*WIDTH-1:0] out_re,
  output logic [4*WIDTH-1:0] out_im,
  output logic               frame_err
);
  logic [3:0] wr_idx_q, wr_idx_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       flag_q, flag_d;
  logic       err_q, err_d;
  logic       resync;
  logic       wbank;
  logic [3:0] waddr;

  logic [RADIX*WIDTH-1:0] bank_re [2];
  logic [RADIX*WIDTH-1:0] bank_im [2];

  // An early SOP abandons the partial frame: the sample goes to slot 0 of
  // the other bank, and the pointer continues from there as for a normal start.
  always_comb begin
    resync    = in_valid & in_sop & (wr_idx_q != 4'd0);
    wbank     = resync ? ~wr_bank_q : wr_bank_q;
    waddr     = resync ? 4'd0 : wr_idx_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    flag_d    = 1'b0;
    err_d     = resync;
    if (in_valid) begin
      wr_idx_d  = waddr + 4'd1;
      wr_bank_d = (waddr == 4'(N - 1)) ? ~wbank : wbank;
      if (waddr == 4'(S_P_FLAG_IDX)) begin
        rd_bank_d = wbank;
        flag_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      s_p_bank #(.WIDTH(WIDTH)) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (in_valid && (wbank == 1'(gi))),
        .waddr_i (waddr),
        .wre_i   (in_re),
        .wim_i   (in_im),
        .sel_i   (sel),
        .rd_re_o (bank_re[gi]),
        .rd_im_o (bank_im[gi])
      );
    end
  endgenerate

  assign out_re       = bank_re[rd_bank_q];
  assign out_im       = bank_im[rd_bank_q];
  assign s_p_flag_out = flag_q;
  assign frame_err    = err_q;
endmodule

// File: tb/tb_s_p_buffer.sv
// Directed bench for s_p_buffer. Each sample is written as re = v and
// im = -v, so every expected lane value is worked out by hand from v.
module tb_s_p_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic [1:0]  sel = '0;
  logic        s_p_flag_out;
  logic [63:0] out_re;
  logic [63:0] out_im;
  logic        frame_err;

  int n_vec = 0;
  int n_err = 0;

  s_p_buffer #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_re        (in_re),
    .in_im        (in_im),
    .sel          (sel),
    .s_p_flag_out (s_p_flag_out),
    .out_re       (out_re),
    .out_im       (out_im),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge. The outputs are then sampled on the
  // next falling edge, once the rising edge in between has captured them.
  task automatic drive(input logic v, input logic sop, input int val);
    in_valid = v;
    in_sop   = sop;
    in_re    = 16'(val);
    in_im    = 16'(-val);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      n_vec++;
      if (out_re !== 64'd0 || out_im !== 64'd0 || s_p_flag_out !== 1'b0 || frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state sel=%0d: re=%h im=%h flag=%b err=%b, required all 0", s, out_re, out_im, s_p_flag_out, frame_err);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: outputs checked at 0 for sel 0..3");
  endtask

  task automatic test_single_frame;
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0, i);
      n_vec++;
      if (s_p_flag_out !== (i == 12) || frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL single_flag i=%0d: flag=%b err=%b, required flag=%b err=0", i, s_p_flag_out, frame_err, i == 12);
      end
    end
    in_valid = 1'b0;
    sel = 2'd1;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp = 16'(1 + 4*j);
      n_vec++;
      if (out_re[j*16 +: 16] !== exp || out_im[j*16 +: 16] !== 16'(-int'(exp))) begin
        n_err++;
        $display("FAIL single_lane j=%0d: re=%0d im=%h, required re=%0d", j, out_re[j*16 +: 16], out_im[j*16 +: 16], exp);
      end
    end
    $display("single frame: 16 samples, sel=1 lanes checked");
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, i == 0, 100*f + i);
        n_vec++;
        if (s_p_flag_out !== (i == 12) || frame_err !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_flag f=%0d i=%0d: flag=%b err=%b, required flag=%b err=0", f, i, s_p_flag_out, frame_err, i == 12);
        end
        if (f == 1 && i == 8) begin
          sel = 2'd3;
          #1;
          for (int j = 0; j < 4; j++) begin
            exp = 16'(3 + 4*j);
            n_vec++;
            if (out_re[j*16 +: 16] !== exp) begin
              n_err++;
              $display("FAIL b2b_frameA_kept j=%0d: re=%0d, required %0d", j, out_re[j*16 +: 16], exp);
            end
          end
        end
      end
    end
    in_valid = 1'b0;
    sel = 2'd3;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp = 16'(103 + 4*j);
      n_vec++;
      if (out_re[j*16 +: 16] !== exp || out_im[j*16 +: 16] !== 16'(-int'(exp))) begin
        n_err++;
        $display("FAIL b2b_frameB j=%0d: re=%0d im=%h, required re=%0d", j, out_re[j*16 +: 16], out_im[j*16 +: 16], exp);
      end
    end
    $display("back to back: frames A and B, sel=3 lanes checked");
  endtask

  task automatic test_gapped;
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0, 50 + i);
      n_vec++;
      if (s_p_flag_out !== (i == 12) || frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL gap_flag i=%0d: flag=%b err=%b, required flag=%b err=0", i, s_p_flag_out, frame_err, i == 12);
      end
      for (int g = 0; g < 2; g++) begin
        drive(1'b0, 1'b1, 999);
        n_vec++;
        if (s_p_flag_out !== 1'b0 || frame_err !== 1'b0) begin
          n_err++;
          $display("FAIL gap_idle i=%0d g=%0d: flag=%b err=%b, required 0 0", i, g, s_p_flag_out, frame_err);
        end
      end
    end
    sel = 2'd0;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp = 16'(50 + 4*j);
      n_vec++;
      if (out_re[j*16 +: 16] !== exp) begin
        n_err++;
        $display("FAIL gap_lane j=%0d: re=%0d, required %0d", j, out_re[j*16 +: 16], exp);
      end
    end
    $display("gapped: valid every 3rd cycle, sel=0 lanes checked");
  endtask

  task automatic test_sop_resync;
    logic [15:0] exp;
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 300 + i);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0, 400 + i);
      n_vec++;
      if (s_p_flag_out !== (i == 12) || frame_err !== (i == 0)) begin
        n_err++;
        $display("FAIL resync i=%0d: flag=%b err=%b, required flag=%b err=%b", i, s_p_flag_out, frame_err, i == 12, i == 0);
      end
    end
    in_valid = 1'b0;
    for (int s = 0; s < 3; s += 2) begin
      sel = 2'(s);
      #1;
      for (int j = 0; j < 4; j++) begin
        exp = 16'(400 + s + 4*j);
        n_vec++;
        if (out_re[j*16 +: 16] !== exp) begin
          n_err++;
          $display("FAIL resync_lane sel=%0d j=%0d: re=%0d, required %0d", s, j, out_re[j*16 +: 16], exp);
        end
      end
    end
    $display("sop resync at wr_idx=7: error pulse and new-frame lanes checked");
  endtask

  task automatic test_async_reset_and_sweep;
    logic [15:0] exp;
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 500 + i);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_re !== 64'd0 || out_im !== 64'd0 || s_p_flag_out !== 1'b0 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: re=%h im=%h flag=%b err=%b, required all 0", out_re, out_im, s_p_flag_out, frame_err);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 600 + i);
      n_vec++;
      if (s_p_flag_out !== (i == 12) || frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset i=%0d: flag=%b err=%b, required flag=%b err=0", i, s_p_flag_out, frame_err, i == 12);
      end
    end
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        exp = 16'(600 + s + 4*j);
        n_vec++;
        if (out_re[j*16 +: 16] !== exp || out_im[j*16 +: 16] !== 16'(-int'(exp))) begin
          n_err++;
          $display("FAIL sweep sel=%0d j=%0d: re=%0d im=%h, required re=%0d", s, j, out_re[j*16 +: 16], out_im[j*16 +: 16], exp);
        end
      end
      n_vec++;
      if (s_p_flag_out !== 1'b0) begin
        n_err++;
        $display("FAIL sweep_noflag sel=%0d: flag=%b, required 0", s, s_p_flag_out);
      end
    end
    $display("async reset mid-frame, then 16 samples and sel sweep checked");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_sop_resync();
    test_async_reset_and_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1);
  end
endmodule
